// File: rtl/game_state_controller.sv
// Breakout-style game sequencer: serve/play/pause/life/win flow, brick alive mask,
// one-kill-per-clock brick arbitration, score and lives bookkeeping.
module game_state_controller #(
  parameter int NUM_BRICKS  = 32,
  parameter int LIVES_INIT  = 3,
  parameter int SERVE_TICKS = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  start_btn,
  input  logic                  pause_btn,
  input  logic [NUM_BRICKS-1:0] brick_hit,
  input  logic                  ball_lost,
  output logic [2:0]            state,
  output logic                  physics_en,
  output logic                  ball_reset,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic [NUM_BRICKS-1:0] kill_ack,
  output logic [15:0]           score,
  output logic [1:0]            lives,
  output logic                  game_over,
  output logic                  game_won
);

  // A zero serve length behaves as a single frame so SERVE always exits.
  localparam int SERVE_LOAD = (SERVE_TICKS < 1) ? 1 : SERVE_TICKS;
  localparam int CNT_W      = $clog2(SERVE_LOAD + 1);
  localparam logic [CNT_W-1:0] SERVE_INIT = CNT_W'(SERVE_LOAD);
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSED    = 3'd3,
    LIFE_LOST = 3'd4,
    GAME_OVER = 3'd5,
    WIN       = 3'd6
  } state_t;

  state_t                  state_reg, state_next;
  logic [NUM_BRICKS-1:0]   alive_reg, alive_next;
  logic [NUM_BRICKS-1:0]   ack_reg, ack_next;
  logic [15:0]             score_reg, score_next;
  logic [1:0]              lives_reg, lives_next;
  logic [CNT_W-1:0]        serve_reg, serve_next;
  logic                    ball_reset_reg, ball_reset_next;
  logic                    physics_reg, physics_next;
  logic                    start_prev_reg, pause_prev_reg;
  logic                    start_edge, pause_edge;
  logic [NUM_BRICKS-1:0]   candidate, first_hit, remaining;
  logic [NUM_BRICKS:0]     seen;
  logic                    any_hit;

  assign start_edge = start_btn & ~start_prev_reg;
  assign pause_edge = pause_btn & ~pause_prev_reg;

  // Lowest-index live brick wins; seen[i] flags any candidate below bit i.
  assign candidate = brick_hit & alive_reg;
  assign seen[0]   = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BRICKS; gi++) begin : g_prio
      assign first_hit[gi]  = candidate[gi] & ~seen[gi];
      assign seen[gi + 1]   = seen[gi] | candidate[gi];
    end
  endgenerate

  assign any_hit   = seen[NUM_BRICKS];
  assign remaining = alive_reg & ~first_hit;

  always_comb begin
    state_next      = state_reg;
    alive_next      = alive_reg;
    ack_next        = '0;
    score_next      = score_reg;
    lives_next      = lives_reg;
    serve_next      = serve_reg;
    ball_reset_next = 1'b0;

    case (state_reg)
      IDLE, GAME_OVER, WIN: begin
        if (start_edge) begin
          alive_next      = '1;
          score_next      = 16'd0;
          lives_next      = LIVES_LOAD;
          serve_next      = SERVE_INIT;
          ball_reset_next = 1'b1;
          state_next      = SERVE;
        end
      end

      SERVE: begin
        if (frame_tick) begin
          if (serve_reg <= CNT_W'(1)) begin
            state_next = PLAY;
          end else begin
            serve_next = serve_reg - CNT_W'(1);
          end
        end
      end

      PLAY: begin
        if (any_hit) begin
          alive_next = remaining;
          ack_next   = first_hit;
          if (score_reg != 16'hFFFF) begin
            score_next = score_reg + 16'd1;
          end
        end
        // Clearing the last brick outranks a simultaneous ball loss or pause.
        if (any_hit && (remaining == '0)) begin
          state_next = WIN;
        end else if (ball_lost) begin
          lives_next = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
          state_next = (lives_reg <= 2'd1) ? GAME_OVER : LIFE_LOST;
        end else if (pause_edge) begin
          state_next = PAUSED;
        end
      end

      PAUSED: begin
        if (pause_edge) begin
          state_next = PLAY;
        end
      end

      LIFE_LOST: begin
        serve_next      = SERVE_INIT;
        ball_reset_next = 1'b1;
        state_next      = SERVE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    physics_next = (state_next == PLAY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      alive_reg      <= '1;
      ack_reg        <= '0;
      score_reg      <= 16'd0;
      lives_reg      <= LIVES_LOAD;
      serve_reg      <= '0;
      ball_reset_reg <= 1'b0;
      physics_reg    <= 1'b0;
      start_prev_reg <= 1'b1;
      pause_prev_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      alive_reg      <= alive_next;
      ack_reg        <= ack_next;
      score_reg      <= score_next;
      lives_reg      <= lives_next;
      serve_reg      <= serve_next;
      ball_reset_reg <= ball_reset_next;
      physics_reg    <= physics_next;
      start_prev_reg <= start_btn;
      pause_prev_reg <= pause_btn;
    end
  end

  assign state       = state_reg;
  assign physics_en  = physics_reg;
  assign ball_reset  = ball_reset_reg;
  assign brick_alive = alive_reg;
  assign kill_ack    = ack_reg;
  assign score       = score_reg;
  assign lives       = lives_reg;
  assign game_over   = (state_reg == GAME_OVER);
  assign game_won    = (state_reg == WIN);

endmodule

// File: tb/tb_game_state_controller.sv
// Directed scenarios plus randomized play, checked against a behavioural game model.
module tb_game_state_controller;

  localparam int NB = 32;
  localparam int LI = 3;
  localparam int ST = 60;

  logic          clk = 1'b0;
  logic          reset, frame_tick, start_btn, pause_btn, ball_lost;
  logic [NB-1:0] brick_hit;
  logic [2:0]    state;
  logic          physics_en, ball_reset, game_over, game_won;
  logic [NB-1:0] brick_alive, kill_ack;
  logic [15:0]   score;
  logic [1:0]    lives;

  int total = 0;
  int bad   = 0;

  // Behavioural model: game rules expressed on plain integers and bit vectors.
  int            m_state, m_score, m_lives, m_serve;
  logic [NB-1:0] m_alive, m_ack;
  bit            m_ball_reset, m_start_prev, m_pause_prev;

  game_state_controller #(.NUM_BRICKS(NB), .LIVES_INIT(LI), .SERVE_TICKS(ST)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .brick_hit(brick_hit), .ball_lost(ball_lost),
    .state(state), .physics_en(physics_en), .ball_reset(ball_reset),
    .brick_alive(brick_alive), .kill_ack(kill_ack), .score(score), .lives(lives),
    .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit se, pe;
    int k;
    se = start_btn && !m_start_prev;
    pe = pause_btn && !m_pause_prev;
    m_ack = '0;
    m_ball_reset = 0;
    if (!reset) begin
      m_state = 0; m_alive = '1; m_score = 0; m_lives = LI; m_serve = 0;
      m_start_prev = 1; m_pause_prev = 1;
      return;
    end
    m_start_prev = start_btn;
    m_pause_prev = pause_btn;
    case (m_state)
      0, 5, 6: if (se) begin
        m_alive = '1; m_score = 0; m_lives = LI; m_serve = ST;
        m_ball_reset = 1; m_state = 1;
      end
      1: if (frame_tick) begin
        if (m_serve <= 1) m_state = 2;
        else m_serve = m_serve - 1;
      end
      2: begin
        k = -1;
        for (int i = 0; i < NB; i++) begin
          if (brick_hit[i] && m_alive[i]) begin k = i; break; end
        end
        if (k >= 0) begin
          m_alive[k] = 1'b0;
          m_ack[k] = 1'b1;
          if (m_score < 65535) m_score++;
        end
        if (k >= 0 && m_alive == '0) m_state = 6;
        else if (ball_lost) begin
          m_lives--;
          m_state = (m_lives == 0) ? 5 : 4;
        end else if (pe) m_state = 3;
      end
      3: if (pe) m_state = 2;
      4: begin m_state = 1; m_serve = ST; m_ball_reset = 1; end
      default: m_state = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    frame_tick = 0; start_btn = 0; pause_btn = 0; ball_lost = 0; brick_hit = '0;
  endtask

  task automatic serve_frames(input int n);
    frame_tick = 1;
    repeat (n) tick();
    frame_tick = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0; start_btn = 1; pause_btn = 1; brick_hit = '1; ball_lost = 1;
    tick(); tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (brick_alive !== '1) begin bad++; $display("FAIL reset_alive got=%h want=ffffffff", brick_alive); end
    total++; if (score !== 16'd0 || lives !== 2'd3) begin bad++; $display("FAIL reset_score_lives got=%0d/%0d want=0/3", score, lives); end
    total++; if (physics_en !== 1'b0 || ball_reset !== 1'b0 || kill_ack !== '0) begin
      bad++; $display("FAIL reset_pulses got=%b%b%h want=00 0", physics_en, ball_reset, kill_ack); end
    brick_hit = '0; ball_lost = 0;
    reset = 1;
    tick(); tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL held_start_after_reset got=%0d want=0", state); end
    idle_inputs();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_serve();
    start_btn = 1;
    tick();
    total++; if (state !== 3'd1 || ball_reset !== 1'b1) begin
      bad++; $display("FAIL serve_entry got=%0d/%b want=1/1", state, ball_reset); end
    tick();
    total++; if (ball_reset !== 1'b0) begin bad++; $display("FAIL ball_reset_width got=%b want=0", ball_reset); end
    serve_frames(ST - 1);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL serve_early got=%0d want=1", state); end
    serve_frames(1);
    total++; if (state !== 3'd2 || physics_en !== 1'b1) begin
      bad++; $display("FAIL serve_to_play got=%0d/%b want=2/1", state, physics_en); end
    start_btn = 0;
    tick();
    $display("test_serve done");
  endtask

  task automatic test_kill();
    brick_hit = 32'h0000_0030;
    tick();
    total++; if (kill_ack !== 32'h10) begin bad++; $display("FAIL kill_first got=%h want=10", kill_ack); end
    tick();
    total++; if (kill_ack !== 32'h20) begin bad++; $display("FAIL kill_second got=%h want=20", kill_ack); end
    total++; if (brick_alive !== 32'hFFFF_FFCF || score !== 16'd2) begin
      bad++; $display("FAIL kill_mask got=%h/%0d want=ffffffcf/2", brick_alive, score); end
    tick();
    total++; if (kill_ack !== '0 || score !== 16'd2) begin
      bad++; $display("FAIL dead_brick_hit got=%h/%0d want=0/2", kill_ack, score); end
    brick_hit = '0;
    tick();
    $display("test_kill done");
  endtask

  task automatic test_pause();
    pause_btn = 1;
    tick();
    total++; if (state !== 3'd3 || physics_en !== 1'b0) begin
      bad++; $display("FAIL pause_enter got=%0d/%b want=3/0", state, physics_en); end
    brick_hit = '1; ball_lost = 1;
    tick();
    total++; if (state !== 3'd3 || kill_ack !== '0 || brick_alive !== 32'hFFFF_FFCF || lives !== 2'd3) begin
      bad++; $display("FAIL paused_ignore got=%0d/%h/%h/%0d want=3/0/ffffffcf/3", state, kill_ack, brick_alive, lives); end
    brick_hit = '0; ball_lost = 0; pause_btn = 0;
    tick();
    pause_btn = 1;
    tick();
    total++; if (state !== 3'd2 || physics_en !== 1'b1) begin
      bad++; $display("FAIL pause_exit got=%0d/%b want=2/1", state, physics_en); end
    pause_btn = 0;
    tick();
    pause_btn = 1; brick_hit = 32'h40;
    tick();
    total++; if (state !== 3'd3 || kill_ack !== 32'h40 || score !== 16'd3) begin
      bad++; $display("FAIL pause_with_kill got=%0d/%h/%0d want=3/40/3", state, kill_ack, score); end
    brick_hit = '0; pause_btn = 0;
    tick();
    pause_btn = 1;
    tick();
    pause_btn = 0;
    tick();
    $display("test_pause done");
  endtask

  task automatic test_lives();
    for (int n = 1; n <= 3; n++) begin
      ball_lost = 1;
      tick();
      ball_lost = 0;
      if (n < 3) begin
        total++; if (state !== 3'd4 || lives !== 2'(LI - n)) begin
          bad++; $display("FAIL life_lost_%0d got=%0d/%0d want=4/%0d", n, state, lives, LI - n); end
        tick();
        total++; if (state !== 3'd1 || ball_reset !== 1'b1) begin
          bad++; $display("FAIL reserve_%0d got=%0d/%b want=1/1", n, state, ball_reset); end
        start_btn = 1;
        tick();
        start_btn = 0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL start_in_serve got=%0d want=1", state); end
        serve_frames(ST);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL replay_%0d got=%0d want=2", n, state); end
      end else begin
        total++; if (state !== 3'd5 || game_over !== 1'b1 || physics_en !== 1'b0 || lives !== 2'd0) begin
          bad++; $display("FAIL game_over got=%0d/%b/%b/%0d want=5/1/0/0", state, game_over, physics_en, lives); end
      end
    end
    $display("test_lives done");
  endtask

  task automatic test_win();
    start_btn = 1;
    tick();
    total++; if (state !== 3'd1 || score !== 16'd0 || lives !== 2'd3 || brick_alive !== '1 || ball_reset !== 1'b1) begin
      bad++; $display("FAIL restart got=%0d/%0d/%0d/%h/%b want=1/0/3/ffffffff/1", state, score, lives, brick_alive, ball_reset); end
    start_btn = 0;
    serve_frames(ST);
    brick_hit = 32'hFFFF_FFFE;
    repeat (NB - 1) tick();
    total++; if (brick_alive !== 32'h1 || score !== 16'd31 || state !== 3'd2) begin
      bad++; $display("FAIL clear_31 got=%h/%0d/%0d want=1/31/2", brick_alive, score, state); end
    brick_hit = 32'h1; ball_lost = 1;
    tick();
    total++; if (state !== 3'd6 || game_won !== 1'b1 || lives !== 2'd3 || kill_ack !== 32'h1 || brick_alive !== '0) begin
      bad++; $display("FAIL win got=%0d/%b/%0d/%h/%h want=6/1/3/1/0", state, game_won, lives, kill_ack, brick_alive); end
    idle_inputs();
    tick();
    total++; if (state !== 3'd6 || kill_ack !== '0 || score !== 16'd32) begin
      bad++; $display("FAIL win_hold got=%0d/%h/%0d want=6/0/32", state, kill_ack, score); end
    $display("test_win done");
  endtask

  task automatic test_reset_midplay();
    start_btn = 1;
    tick();
    start_btn = 0;
    serve_frames(ST);
    brick_hit = 32'h1F;
    repeat (5) tick();
    brick_hit = '0;
    total++; if (score !== 16'd5) begin bad++; $display("FAIL score_five got=%0d want=5", score); end
    reset = 0; start_btn = 1;
    tick();
    total++; if (state !== 3'd0 || score !== 16'd0 || brick_alive !== '1 || physics_en !== 1'b0) begin
      bad++; $display("FAIL midplay_reset got=%0d/%0d/%h/%b want=0/0/ffffffff/0", state, score, brick_alive, physics_en); end
    reset = 1;
    repeat (3) begin
      tick();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL held_start_release got=%0d want=0", state); end
    end
    start_btn = 0;
    tick();
    $display("test_reset_midplay done");
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 799) != 0);
      frame_tick = ($urandom_range(0, 1) == 0);
      ball_lost  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 14) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 19) == 0) pause_btn = ~pause_btn;
      r = $urandom_range(0, 9);
      if (r <= 5)      brick_hit = '0;
      else if (r <= 7) brick_hit = NB'(1) << $urandom_range(0, NB - 1);
      else if (r == 8) brick_hit = $urandom() & $urandom();
      else             brick_hit = '1;
      tick();
      total++; if (state !== 3'(m_state) || physics_en !== (m_state == 2) || game_over !== (m_state == 5) || game_won !== (m_state == 6)) begin
        bad++; $display("FAIL rand_state cyc=%0d got=%0d/%b/%b/%b want=%0d", c, state, physics_en, game_over, game_won, m_state); end
      total++; if (brick_alive !== m_alive || kill_ack !== m_ack) begin
        bad++; $display("FAIL rand_bricks cyc=%0d got=%h/%h want=%h/%h", c, brick_alive, kill_ack, m_alive, m_ack); end
      total++; if (score !== 16'(m_score) || lives !== 2'(m_lives) || ball_reset !== m_ball_reset) begin
        bad++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b", c, score, lives, ball_reset, m_score, m_lives, m_ball_reset); end
    end
    idle_inputs();
    reset = 1;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_serve();
    test_kill();
    test_pause();
    test_lives();
    test_win();
    test_reset_midplay();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
